// File: rtl/r200_pkg.sv
// Shared definitions for the r200 pipeline: data width, NOP encoding, reset PC
// and the fetch queue entry layout.
package r200_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/r200_fetch_fifo.sv
// Prefetch entry storage: entries are allocated with their PC, filled in
// allocation order by memory responses and popped from the head once filled.
module r200_fetch_fifo
  import r200_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     alloc,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic                     fill,
  input  logic [XLEN-1:0]          fill_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [XLEN-1:0]          head_pc,
  output logic [XLEN-1:0]          head_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, fill_ptr, rd_ptr;
  logic          alloc_en, fill_en, pop_en;

  assign head_valid = (count != '0) && mem[rd_ptr].filled;
  assign head_pc    = mem[rd_ptr].pc;
  assign head_instr = mem[rd_ptr].instr;

  assign alloc_en = alloc && (count < CW'(DEPTH));
  assign fill_en  = fill && (pending != '0);
  assign pop_en   = pop && head_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
    end else begin
      // A response is never for the entry allocated in the same cycle, so
      // alloc and fill always address different slots.
      if (alloc_en) begin
        mem[wr_ptr] <= '{pc: alloc_pc, instr: INSTR_NOP, filled: 1'b0};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (fill_en) begin
        mem[fill_ptr].instr  <= fill_data;
        mem[fill_ptr].filled <= 1'b1;
        fill_ptr             <= fill_ptr + AW'(1);
      end
      if (pop_en) rd_ptr <= rd_ptr + AW'(1);
      count   <= count + CW'(alloc_en) - CW'(pop_en);
      pending <= pending + CW'(alloc_en) - CW'(fill_en);
    end
  end

endmodule

// File: rtl/r200_fetch_queue.sv
// r200 instruction fetch front end: fetch PC, credit-limited imem requests,
// redirect flush with drop accounting. R200_FETCH_PERF_EN adds perf counters.
module r200_fetch_queue
  import r200_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instrn,
  output logic [31:0] if_pc_addrout,
  output logic [31:0] if_pcp4
`ifdef R200_FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   fpc;
  logic [CW-1:0] count, pending, drop_cnt;
  logic [CW:0]   credit_sum;
  logic          accept, rsp_fill, rsp_drop, pop;
  logic          head_valid;
  logic [31:0]   head_pc, head_instr;
  logic [1:0]    unused_redirect_lo;

  assign unused_redirect_lo = redirect_pc[1:0];

  assign credit_sum     = {1'b0, count} + {1'b0, drop_cnt};
  assign imem_req_valid = rst_n && (credit_sum < (CW+1)'(DEPTH)) && !redirect;
  assign imem_req_addr  = fpc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid && (drop_cnt == '0);
  assign pop      = head_valid && !stall && !redirect;

  r200_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .alloc      (accept),
    .alloc_pc   (fpc),
    .fill       (rsp_fill),
    .fill_data  (imem_rsp_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (count),
    .pending    (pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc      <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect) begin
      fpc      <= {redirect_pc[31:2], 2'b00};
      // Every outstanding request is owed a response; one arriving now
      // retires either a drop or a pending entry, so it is subtracted once.
      drop_cnt <= drop_cnt + pending - CW'(imem_rsp_valid);
    end else begin
      if (accept)   fpc      <= fpc + 32'd4;
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  assign if_valid      = head_valid;
  assign if_instrn     = head_valid ? head_instr : INSTR_NOP;
  assign if_pc_addrout = head_valid ? head_pc : fpc;
  assign if_pcp4       = if_pc_addrout + 32'd4;

`ifdef R200_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt   <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (!head_valid && !stall) perf_bubble_cnt   <= perf_bubble_cnt + 32'd1;
      if (redirect)              perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_r200_fetch_queue.sv
// Directed bench for r200_fetch_queue with an in-order fixed-latency memory model.
module tb_r200_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instrn;
  logic [31:0] if_pc_addrout;
  logic [31:0] if_pcp4;

  int n_chk  = 0;
  int n_fail = 0;

  int unsigned cyc = 0;
  int unsigned lat = 1;
  logic [31:0] q_addr[$];
  int unsigned q_due[$];

  r200_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_instrn      (if_instrn),
    .if_pc_addrout  (if_pc_addrout),
    .if_pcp4        (if_pcp4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory returns instruction = addr ^ 0xC0DE0000, exactly lat cycles after accept.
  task automatic tick();
    if (rst_n && imem_req_valid && imem_req_ready) begin
      q_addr.push_back(imem_req_addr);
      q_due.push_back(cyc + lat);
    end
    @(posedge clk);
    cyc++;
    #1;
    imem_rsp_valid = 1'b0;
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = q_addr[0] ^ 32'hC0DE_0000;
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect       = 1'b0;
    stall          = 1'b0;
    q_addr.delete();
    q_due.delete();
    #1;
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_pc", if_pc_addrout, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    #1;
    chk("reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("reset_if_valid", {31'b0, if_valid}, 32'd0);
    chk("reset_instr", if_instrn, 32'h0000_0013);
    chk("reset_pc", if_pc_addrout, 32'h0);
    chk("reset_pcp4", if_pcp4, 32'h4);
    tick();
    tick();

    // Streaming, L=1, no stall
    lat = 1; rst_n = 1'b1; #1;
    chk("t1_c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t1_c0_addr", imem_req_addr, 32'h0);
    tick(); #1;
    chk("t1_c1_if_valid", {31'b0, if_valid}, 32'd0);
    chk("t1_c1_addr", imem_req_addr, 32'h4);
    tick(); #1;
    chk("t1_c2_if_valid", {31'b0, if_valid}, 32'd1);
    chk("t1_c2_pc", if_pc_addrout, 32'h0);
    chk("t1_c2_pcp4", if_pcp4, 32'h4);
    chk("t1_c2_instr", if_instrn, 32'hC0DE_0000);
    chk("t1_c2_addr", imem_req_addr, 32'h8);
    tick(); #1;
    chk("t1_c3_pc", if_pc_addrout, 32'h4);
    chk("t1_c3_pcp4", if_pcp4, 32'h8);
    tick(); #1;
    chk("t1_c4_pc", if_pc_addrout, 32'h8);
    chk("t1_c4_pcp4", if_pcp4, 32'hC);

    // Stall held, L=2: queue fills to DEPTH; then ready held low
    do_reset();
    lat = 2; stall = 1'b1; imem_req_ready = 1'b1; #1;
    tick(); tick(); tick(); tick(); #1;
    chk("t2_c4_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t2_c4_if_valid", {31'b0, if_valid}, 32'd1);
    tick(); tick(); #1;
    chk("t2_c6_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t2_c6_pc", if_pc_addrout, 32'h0);
    stall = 1'b0;
    tick();
    stall = 1'b1; imem_req_ready = 1'b0; #1;
    chk("t2_c7_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t2_c7_addr", imem_req_addr, 32'h10);
    chk("t2_c7_pc", if_pc_addrout, 32'h4);
    tick(); #1;
    chk("t3_c8_addr", imem_req_addr, 32'h10);
    tick(); #1;
    chk("t3_c9_addr", imem_req_addr, 32'h10);
    chk("t3_c9_req_valid", {31'b0, imem_req_valid}, 32'd1);
    tick();
    imem_req_ready = 1'b1; #1;
    chk("t3_c10_addr", imem_req_addr, 32'h10);
    tick(); #1;
    chk("t3_c11_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t3_c11_pc", if_pc_addrout, 32'h4);
    stall = 1'b0;
    tick(); #1;
    chk("t3_c12_pc", if_pc_addrout, 32'h8);
    tick(); #1;
    chk("t3_c13_pc", if_pc_addrout, 32'hC);
    tick(); #1;
    chk("t3_c14_pc", if_pc_addrout, 32'h10);
    chk("t3_c14_instr", if_instrn, 32'hC0DE_0010);
    tick(); #1;
    chk("t3_c15_pc", if_pc_addrout, 32'h14);

    // Redirect to 0x100 with two outstanding requests, L=3
    do_reset();
    lat = 3; imem_req_ready = 1'b1; #1;
    tick(); tick();
    imem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100; #1;
    chk("t4_c2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect = 1'b0; imem_req_ready = 1'b1; #1;
    chk("t4_c3_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t4_c3_addr", imem_req_addr, 32'h100);
    chk("t4_c3_if_valid", {31'b0, if_valid}, 32'd0);
    tick(); #1;
    chk("t4_c4_if_valid", {31'b0, if_valid}, 32'd0);
    tick(); #1;
    chk("t4_c5_if_valid", {31'b0, if_valid}, 32'd0);
    tick(); #1;
    chk("t4_c6_if_valid", {31'b0, if_valid}, 32'd0);
    tick(); #1;
    chk("t4_c7_if_valid", {31'b0, if_valid}, 32'd1);
    chk("t4_c7_pc", if_pc_addrout, 32'h100);
    chk("t4_c7_instr", if_instrn, 32'hC0DE_0100);
    chk("t4_c7_pcp4", if_pcp4, 32'h104);

    // Redirect coincident with a response (for 0x104), target 0x203
    redirect = 1'b1; redirect_pc = 32'h203; #1;
    chk("t5_c7_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect = 1'b0; #1;
    chk("t5_c8_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t5_c8_addr", imem_req_addr, 32'h200);
    chk("t5_c8_if_valid", {31'b0, if_valid}, 32'd0);
    tick(); tick(); tick(); #1;
    chk("t5_c11_if_valid", {31'b0, if_valid}, 32'd0);
    tick(); #1;
    chk("t5_c12_if_valid", {31'b0, if_valid}, 32'd1);
    chk("t5_c12_pc", if_pc_addrout, 32'h200);
    chk("t5_c12_instr", if_instrn, 32'hC0DE_0200);

    // Fetch PC wrap at 2^32
    do_reset();
    lat = 1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    chk("t6_c0_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect = 1'b0; #1;
    chk("t6_c1_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("t6_c2_addr", imem_req_addr, 32'h0);
    tick(); #1;
    chk("t6_c3_pc", if_pc_addrout, 32'hFFFF_FFFC);
    chk("t6_c3_pcp4", if_pcp4, 32'h0);
    tick(); #1;
    chk("t6_c4_pc", if_pc_addrout, 32'h0);
    chk("t6_c4_pcp4", if_pcp4, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/r200_fetch_queue.md
# r200_fetch_queue

Instruction fetch front end for the r200 five-stage pipeline, sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues in-order requests to instruction memory over a valid/ready channel. Fixed-latency-agnostic responses are buffered in a small prefetch queue. The queue presents one instruction per cycle, with its PC and PC+4, to the decode stage, honouring decode stalls and execute-stage redirects.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- DEPTH, 4, queue entries; power of two, 2..16
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; in order, no backpressure, ≥1 cycle after accept
- imem_rsp_data  in  32  instruction word
- redirect  in  1  branch/jump resolved taken in execute
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (forced 0)
- stall  in  1  decode holds; head entry not consumed
- if_valid  out  1  head instruction valid
- if_instrn  out  32  head instruction
- if_pc_addrout  out  32  PC of head instruction
- if_pcp4  out  32  if_pc_addrout + 4, mod 2^32

## Operation
- Entries are allocated at request accept. Each entry stores its PC and is marked filled when the matching response arrives. Responses fill entries strictly in allocation order.
- Credit rule: imem_req_valid = (allocated + drop_cnt) < DEPTH and not redirect.
- Accept (valid && ready): allocate an entry with PC = fpc, then fpc <= fpc + 4 (wraps at 2^32).
- Head output: if_valid = head entry allocated and filled. Pop when if_valid && !stall.
- imem_req_addr holds stable while valid && !ready. It may change only after accept or redirect.
- Redirect:
  - Flush all entries.
  - Set fpc <= {redirect_pc[31:2],2'b00}.
  - Set drop_cnt <= number of requests accepted but not yet responded, including any accepted in the redirect cycle and excluding any response arriving in that cycle.
- Drop handling: while drop_cnt > 0, each response is discarded and drop_cnt decrements. Responses never fill post-redirect entries while drop_cnt > 0.
- Simultaneous events:
  - Redirect beats stall and pop. Nothing is popped in the redirect cycle.
  - Fill and pop in the same cycle on a non-full queue are both honoured.
  - A response to an empty, filled-free queue becomes visible the next cycle.
- Counters allocated and drop_cnt are $clog2(DEPTH)+1 bits wide.

## Timing
- Reset values: fpc = RESET_PC, queue empty, drop_cnt = 0.
  - imem_req_valid = 0, if_valid = 0.
  - if_instrn = 32'h0000_0013 (NOP).
  - if_pc_addrout = RESET_PC, if_pcp4 = RESET_PC + 4.
- First request: the first cycle after rst_n deasserts, imem_req_valid = 1 with addr = RESET_PC.
- Latency: accept in cycle N, response in cycle N+L, if_valid in cycle N+L+1 (empty queue). Steady-state throughput is 1 instruction/cycle when L < DEPTH.
- Redirect in cycle R:
  - if_valid = 0 in R+1.
  - imem_req_valid = 1 with redirect_pc in R+1, if credits allow.
- rst_n assertion mid-transfer clears everything immediately. The bench must not return pre-reset responses after reset.

## Configuration
- R200_FETCH_PERF_EN defined: adds output perf_bubble_cnt (32) and output perf_redirect_cnt (32).
  - perf_bubble_cnt increments each cycle with if_valid == 0 && !stall.
  - perf_redirect_cnt increments on each redirect.
  - Both reset to 0 and wrap at 2^32.
- Undefined: these ports and their counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package r200_pkg holds:
  - XLEN = 32.
  - INSTR_NOP = 32'h0000_0013.
  - DEFAULT_RESET_PC.
  - The fetch entry struct typedef (pc, instr, filled).
- Sub-module r200_fetch_fifo holds the entry storage with alloc/fill/pop pointers, wrap-around indexing, full/empty flags and flush. The top holds fpc, credits and drop_cnt.

## Test plan
- Reset release, ready=1, L=1, no stall: requests at addresses 0x0, 0x4, 0x8 in consecutive cycles. if_valid first rises 2 cycles after the first accept; PCs then appear 0x0, 0x4, 0x8 with if_pcp4 0x4, 0x8, 0xC.
- Stall held, L=2, DEPTH=4: exactly 4 requests are accepted, then imem_req_valid = 0. Releasing stall pops the head, and one new request issues the next cycle.
- imem_req_ready low for 3 cycles: imem_req_addr is held at 0x10 throughout. There is no duplicate entry after accept.
- Redirect to 0x100 with 2 requests outstanding (L=3): both late responses are discarded. The first if_valid shows PC 0x100 with the instruction returned for 0x100.
- Redirect and a response in the same cycle, with redirect_pc = 0x203: drop_cnt excludes that response, and the next request address is 0x200.
- fpc = 0xFFFF_FFFC: the next request address wraps to 0x0, and if_pcp4 = 0x0 for that head entry.
